// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the bit-serial adder/subtractor.
//   adder_state_t : control FSM encoding (IDLE, ADD, DONE)
//   MODE_ADD      : mode value selecting a + b + carry_in
//   MODE_SUB      : mode value selecting a - b
// ---------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } adder_state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : adder_pkg

// File: rtl/adder_1bit.sv
// ---------------------------------------------------------------------------
// adder_1bit
// One-bit full-adder cell, the per-bit datapath of adder_serial.
// Ports:
//   a, b  in  operand bits
//   cin   in  carry in
//   s     out sum bit  (a ^ b ^ cin)
//   cout  out carry out (majority of a, b, cin)
// ---------------------------------------------------------------------------
module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : adder_1bit

// File: rtl/adder_serial.sv
// ---------------------------------------------------------------------------
// adder_serial
// Bit-serial adder/subtractor: one result bit per clock through a single
// full-adder cell, LSB first. An operation takes BIT_WIDTH cycles in ADD and
// one cycle in DONE, so a new start is accepted every BIT_WIDTH+2 cycles.
//
// Handshake: start is sampled only in IDLE. The edge that sees start = 1 in
// IDLE captures a, b, mode and carry_in and raises busy. busy stays high for
// exactly BIT_WIDTH cycles; done then pulses for one cycle, together with the
// new sum/carry_out/overflow, which hold until the next completion. start
// seen in ADD or DONE is dropped, never queued.
//
// Ports:
//   clk        in  clock, rising edge
//   rst        in  asynchronous active-high reset
//   start      in  request an operation (IDLE only)
//   mode       in  MODE_ADD: a + b + carry_in, MODE_SUB: a - b
//   a, b       in  operands [BIT_WIDTH-1:0]
//   carry_in   in  carry into bit 0 for add, ignored for subtract
//   sum        out result [BIT_WIDTH-1:0]
//   carry_out  out carry out of the MSB (subtract: 1 = no borrow)
//   overflow   out two's-complement overflow
//   busy       out high while in ADD
//   done       out one-cycle completion pulse
//   state_dbg  out current FSM state (adder_state_t encoding)
// ---------------------------------------------------------------------------
module adder_serial
    import adder_pkg::*;
#(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 carry_out,
    output logic                 overflow,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           state_dbg
);

    // Counter must be at least one bit wide even for tiny widths.
    localparam int CNT_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIT_WIDTH - 1);

    adder_state_t         state;
    logic [BIT_WIDTH-1:0] a_sr;
    logic [BIT_WIDTH-1:0] b_sr;
    logic [BIT_WIDTH-1:0] res_sr;
    logic                 carry;
    logic [CNT_W-1:0]     bit_cnt;

    logic                 fa_sum;
    logic                 fa_cout;

    // Result register after this edge's shift; on the last ADD edge this is
    // the complete result and is copied straight into sum.
    logic [BIT_WIDTH-1:0] res_next;

    adder_1bit u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_sum),
        .cout (fa_cout)
    );

    assign res_next  = {fa_sum, res_sr[BIT_WIDTH-1:1]};
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sr      <= '0;
            b_sr      <= '0;
            res_sr    <= '0;
            carry     <= 1'b0;
            bit_cnt   <= '0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr    <= a;
                        // Subtract is a + ~b + 1: invert B and force carry in.
                        b_sr    <= (mode == MODE_ADD) ? b : ~b;
                        carry   <= (mode == MODE_SUB) ? 1'b1 : carry_in;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= ADD;
                    end
                end

                ADD: begin
                    res_sr  <= res_next;
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    carry   <= fa_cout;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        // On this edge 'carry' is still the carry into the
                        // MSB and fa_cout is the carry out of it, so their
                        // XOR is the signed overflow.
                        sum       <= res_next;
                        carry_out <= fa_cout;
                        overflow  <= carry ^ fa_cout;
                        bit_cnt   <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : adder_serial
